// File: rtl/aes_spi_slave_if.sv
// rtl/aes_spi_slave_if.sv - SPI mode-0 slave front end for the AES core
// Receives plaintext+key in one CS frame, returns ciphertext in a later frame.
module aes_spi_slave_if #(
   parameter int Nk          = 4,
   parameter int BLOCK_W     = 128,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sclk,
   input  logic                cs_n,
   input  logic                sdi,
   output logic                sdo,
   output logic [BLOCK_W-1:0]  pt_out,
   output logic [32*Nk-1:0]    key_out,
   output logic                frame_valid,
   input  logic [BLOCK_W-1:0]  ct_in,
   input  logic                ct_valid,
   output logic                busy,
   output logic                frame_err
);
   localparam int KEY_W = 32 * Nk;
   localparam int TOTAL = BLOCK_W + KEY_W;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);

   typedef enum logic [2:0] {IDLE, RX, WAIT_CT, READY, TX} state_t;

   state_t                  state, state_nxt;
   logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, sdi_sync;
   logic                    sclk_d, cs_d;
   logic [TOTAL-1:0]        rx_sr, rx_sr_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic                    ovf, ovf_nxt;
   logic [BLOCK_W-1:0]      tx_sr, tx_sr_nxt;
   logic                    load_rx, fv_set, err_set, fv_pend, err_pend;

   // The delayed copies give edge detection one registered stage past the synchroniser
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         sdi_sync  <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
         cs_d      <= cs_sync[SYNC_STAGES-1];
      end
   end

   logic sclk_s, cs_s, sdi_s, sclk_rise, sclk_fall, cs_rise, cs_fall;
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;

   always_comb begin
      state_nxt = state;
      rx_sr_nxt = rx_sr;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf;
      tx_sr_nxt = tx_sr;
      load_rx   = 1'b0;
      fv_set    = 1'b0;
      err_set   = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               state_nxt = RX;
               rx_sr_nxt = '0;
               cnt_nxt   = '0;
               ovf_nxt   = 1'b0;
            end
         end
         RX: begin
            // A coincident final sclk sample is folded in before the cs_n rise is judged
            if (sclk_rise) begin
               rx_sr_nxt = {rx_sr[TOTAL-2:0], sdi_s};
               if (cnt == TOTAL_C) ovf_nxt = 1'b1;
               else                cnt_nxt = cnt + CNT_W'(1);
            end
            if (cs_rise) begin
               if (cnt_nxt == TOTAL_C && !ovf_nxt) begin
                  load_rx   = 1'b1;
                  fv_set    = 1'b1;
                  state_nxt = WAIT_CT;
               end else begin
                  err_set   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         WAIT_CT: begin
            if (ct_valid) begin
               tx_sr_nxt = ct_in;
               state_nxt = READY;
            end
         end
         READY: begin
            if (cs_fall) state_nxt = TX;
         end
         TX: begin
            if (sclk_fall) tx_sr_nxt = {tx_sr[BLOCK_W-2:0], 1'b0};
            if (cs_rise)   state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rx_sr       <= '0;
         cnt         <= '0;
         ovf         <= 1'b0;
         tx_sr       <= '0;
         pt_out      <= '0;
         key_out     <= '0;
         fv_pend     <= 1'b0;
         err_pend    <= 1'b0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         state       <= state_nxt;
         rx_sr       <= rx_sr_nxt;
         cnt         <= cnt_nxt;
         ovf         <= ovf_nxt;
         tx_sr       <= tx_sr_nxt;
         fv_pend     <= fv_set;
         err_pend    <= err_set;
         frame_valid <= fv_pend;
         frame_err   <= err_pend;
         if (load_rx) begin
            pt_out  <= rx_sr_nxt[TOTAL-1 -: BLOCK_W];
            key_out <= rx_sr_nxt[KEY_W-1:0];
         end
      end
   end

   assign busy = (state != IDLE);
   assign sdo  = (state == TX && !cs_s) ? tx_sr[BLOCK_W-1] : 1'b0;

endmodule
